truth_table_capture: RTL

//   Sequential reader for the 4-input combinational function blocks (s = f(x,y,w,z)).
//   On start, it sweeps all 2**N input combinations in ascending order.
//   It waits for the function to settle, samples s and assembles the captured truth table.
//   It reports the maxterm count (zeros of s = clauses in canonical POS).
//   It sits between a stimulus/control bench or top level and a function-under-test.

---
 rtl/truth_table_capture.sv | 135 +++++++++++++
 1 files changed

// File: rtl/truth_table_capture.sv
// Sweeps every input combination of a small combinational function, samples its
// output and assembles the truth table plus its maxterm count. Optional
// expected-table comparison is built when EXPECT_CHECK_EN is defined.
module truth_table_capture #(
    parameter int N_INPUTS      = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [N_INPUTS-1:0]      drive,
    input  logic                     s_in,
    output logic                     busy,
    output logic                     done,
    output logic [(2**N_INPUTS)-1:0] table_out,
    output logic [N_INPUTS:0]        maxterm_cnt
`ifdef EXPECT_CHECK_EN
    ,
    input  logic [(2**N_INPUTS)-1:0] exp_table,
    output logic                     match,
    output logic [N_INPUTS-1:0]      first_bad
`endif
);

    localparam int TW = 2**N_INPUTS;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]       CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [N_INPUTS-1:0] idx;
    logic [CW-1:0]       cnt;
    logic [TW-1:0]       table_nxt;

    // Table as it will look once the current sample is written; also feeds the
    // compare so match/first_bad are valid in the same cycle as done.
    always_comb begin
        table_nxt      = table_out;
        table_nxt[idx] = s_in;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        drive     = idx;
        case (state)
            IDLE: begin
                busy  = 1'b0;
                drive = '0;
                if (start) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == CNT_LAST) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                state_nxt = (idx == IDX_LAST) ? DONE : SETTLE;
            end
            DONE: begin
                done      = 1'b1;
                drive     = IDX_LAST;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef EXPECT_CHECK_EN
    logic [TW-1:0]       diff;
    logic [N_INPUTS-1:0] bad_idx;

    always_comb begin
        diff    = table_nxt ^ exp_table;
        bad_idx = '0;
        for (int i = TW - 1; i >= 0; i--) begin
            if (diff[i]) bad_idx = N_INPUTS'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            table_out   <= '0;
            maxterm_cnt <= '0;
`ifdef EXPECT_CHECK_EN
            match       <= 1'b0;
            first_bad   <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx         <= '0;
                        cnt         <= '0;
                        table_out   <= '0;
                        maxterm_cnt <= '0;
`ifdef EXPECT_CHECK_EN
                        match       <= 1'b0;
                        first_bad   <= '0;
`endif
                    end
                end
                SETTLE: cnt <= cnt + 1'b1;
                SAMPLE: begin
                    table_out   <= table_nxt;
                    maxterm_cnt <= maxterm_cnt + {{N_INPUTS{1'b0}}, ~s_in};
                    if (idx != IDX_LAST) begin
                        idx <= idx + 1'b1;
                        cnt <= '0;
                    end
`ifdef EXPECT_CHECK_EN
                    else begin
                        match     <= (diff == '0);
                        first_bad <= bad_idx;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
